// File: rtl/mulmul_pkg.sv
// rtl/mulmul_pkg.sv - shared types and constants for the mulmul shift-add multiplier
package mulmul_pkg;

    localparam int MULMUL_WIDTH_DEFAULT = 32;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_HOLD = 2'd2
    } mulmul_state_t;

    function automatic int mulmul_cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/mulmul_datapath.sv
// rtl/mulmul_datapath.sv - operand shift registers, accumulator, adder and iteration counter
module mulmul_datapath
    import mulmul_pkg::*;
#(
    parameter int WIDTH = MULMUL_WIDTH_DEFAULT
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic               step,
    input  logic [WIDTH-1:0]   multiplicand,
    input  logic [WIDTH-1:0]   multiplier,
    output logic [2*WIDTH-1:0] sum,
    output logic               last
);

    localparam int CW = mulmul_cnt_width(WIDTH);

    logic [2*WIDTH-1:0] a_sh;
    logic [2*WIDTH-1:0] acc;
    logic [WIDTH-1:0]   b_sh;
    logic [CW-1:0]      cnt;

    // sum is the accumulator value after the current step; on the final step it is the product
    always_comb begin
        sum  = b_sh[0] ? (acc + a_sh) : acc;
        last = (cnt == CW'(WIDTH - 1));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_sh <= '0;
            b_sh <= '0;
            acc  <= '0;
            cnt  <= '0;
        end else if (load) begin
            a_sh <= {{WIDTH{1'b0}}, multiplicand};
            b_sh <= multiplier;
            acc  <= '0;
            cnt  <= '0;
        end else if (step) begin
            a_sh <= a_sh << 1;
            b_sh <= b_sh >> 1;
            acc  <= sum;
            cnt  <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/mulmul.sv
// rtl/mulmul.sv - sequential unsigned shift-add multiplier, one multiplier bit per clock
module mulmul
    import mulmul_pkg::*;
#(
    parameter int WIDTH = MULMUL_WIDTH_DEFAULT
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               enable,
    input  logic [WIDTH-1:0]   multiplicand,
    input  logic [WIDTH-1:0]   multiplier,
    output logic [2*WIDTH-1:0] product,
    output logic               overflow,
    output logic               busy,
    output logic               done
);

    mulmul_state_t      state;
    mulmul_state_t      state_nxt;
    logic               load;
    logic               step;
    logic               last;
    logic [2*WIDTH-1:0] sum;

    mulmul_datapath #(.WIDTH(WIDTH)) u_datapath (
        .clk          (clk),
        .rst          (rst),
        .load         (load),
        .step         (step),
        .multiplicand (multiplicand),
        .multiplier   (multiplier),
        .sum          (sum),
        .last         (last)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    // HOLD keeps a level-high enable from retriggering a second operation
    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        step      = 1'b0;
        case (state)
            S_IDLE: begin
                if (enable) begin
                    load      = 1'b1;
                    state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                step = 1'b1;
                if (last) state_nxt = enable ? S_HOLD : S_IDLE;
            end
            S_HOLD: begin
                if (!enable) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            product  <= '0;
            overflow <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= step && last;
            if (step && last) begin
                product  <= sum;
                overflow <= |sum[2*WIDTH-1:WIDTH];
            end
        end
    end

    assign busy = (state == S_RUN);

endmodule

// File: tb/tb_mulmul.sv
// tb/tb_mulmul.sv - self-checking bench for mulmul against a behavioural multiply model
module tb_mulmul;

    localparam int W = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          enable;
    logic [W-1:0]  multiplicand;
    logic [W-1:0]  multiplier;
    logic [2*W-1:0] product;
    logic          overflow;
    logic          busy;
    logic          done;

    int compared   = 0;
    int mismatched = 0;
    int n_done     = 0;

    mulmul #(.WIDTH(W)) dut (
        .clk          (clk),
        .rst          (rst),
        .enable       (enable),
        .multiplicand (multiplicand),
        .multiplier   (multiplier),
        .product      (product),
        .overflow     (overflow),
        .busy         (busy),
        .done         (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: an operation captured at an edge completes WIDTH edges later
    longint unsigned m_prod, m_val, a64, b64;
    bit m_ovf, m_done, m_busy, m_wait_drop;
    int m_rem;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_prod = 0; m_val = 0; m_ovf = 0; m_done = 0;
            m_busy = 0; m_wait_drop = 0; m_rem = 0;
        end else begin
            m_done = 0;
            if (m_busy) begin
                m_rem = m_rem - 1;
                if (m_rem == 0) begin
                    m_busy      = 0;
                    m_prod      = m_val;
                    m_ovf       = (m_val >> 32) != 0;
                    m_done      = 1;
                    m_wait_drop = enable;
                end
            end else if (m_wait_drop) begin
                if (!enable) m_wait_drop = 0;
            end else if (enable) begin
                a64    = multiplicand;
                b64    = multiplier;
                m_val  = a64 * b64;
                m_busy = 1;
                m_rem  = W;
            end
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            chk("busy", 64'(busy), 64'(m_busy));
            chk("done", 64'(done), 64'(m_done));
            chk("product", product, m_prod);
            chk("overflow", 64'(overflow), 64'(m_ovf));
            if (done) n_done++;
        end
    end

    // Starts one operation, keeps enable high for en_cycles edges, returns done latency in cycles
    task automatic op(input logic [W-1:0] a, input logic [W-1:0] b, input int en_cycles,
                      input bit scramble, output int lat);
        @(negedge clk);
        multiplicand = a;
        multiplier   = b;
        enable       = 1'b1;
        lat          = -1;
        for (int i = 1; i <= en_cycles + 40; i++) begin
            @(negedge clk);
            if (done && lat < 0) lat = i;
            if (i >= en_cycles) enable = 1'b0;
            if (scramble) begin
                multiplicand = $urandom;
                multiplier   = $urandom;
            end
        end
        if (lat < 0) begin
            compared++;
            mismatched++;
            $display("FAIL op_timeout: no done within %0d cycles", en_cycles + 40);
        end
    endtask

    int lat, d0;
    logic [63:0] q, exp_v;

    initial begin
        rst = 1'b1; enable = 1'b0; multiplicand = '0; multiplier = '0;
        repeat (3) @(negedge clk);
        chk("rst_product", product, 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_overflow", 64'(overflow), 64'd0);
        rst = 1'b0;

        // basic with level-high enable: single operation, WIDTH cycles after capture
        d0 = n_done;
        op(32'd7, 32'd52, 100, 1'b0, lat);
        chk("basic_lat", 64'(lat), 64'(W + 1));
        chk("basic_product", product, 64'd364);
        chk("basic_overflow", 64'(overflow), 64'd0);
        chk("basic_one_done", 64'(n_done - d0), 64'd1);

        // reset mid-run aborts without a done pulse
        d0 = n_done;
        @(negedge clk);
        multiplicand = 32'd5; multiplier = 32'd6; enable = 1'b1;
        @(negedge clk);
        enable = 1'b0;
        repeat (9) @(negedge clk);
        chk("pre_rst_busy", 64'(busy), 64'd1);
        rst = 1'b1;
        #1;
        chk("midrst_product", product, 64'd0);
        chk("midrst_busy", 64'(busy), 64'd0);
        chk("midrst_done", 64'(done), 64'd0);
        chk("midrst_no_done", 64'(n_done - d0), 64'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        op(32'd5, 32'd6, 1, 1'b0, lat);
        chk("after_rst_product", product, 64'd30);

        // divider inverse sweep
        for (int qq = 1; qq <= 58; qq += 3) begin
            q = 64'(qq);
            op(W'(qq), W'(q * q + 7), 2, 1'b0, lat);
            exp_v = q * q * q + 7 * q;
            chk("sweep_product", product, exp_v);
        end

        op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 3, 1'b0, lat);
        chk("max_product", product, 64'hFFFF_FFFE_0000_0001);
        chk("max_overflow", 64'(overflow), 64'd1);

        op(32'd0, 32'hFFFF_FFFF, 3, 1'b0, lat);
        chk("zero_product", product, 64'd0);
        chk("zero_overflow", 64'(overflow), 64'd0);
        chk("zero_lat", 64'(lat), 64'(W + 1));

        op(32'h1_0000, 32'h1_0000, 3, 1'b0, lat);
        chk("pow_product", product, 64'h1_0000_0000);
        chk("pow_overflow", 64'(overflow), 64'd1);

        // back-to-back: restart right when done shows, operands scrambled during run
        @(negedge clk);
        multiplicand = 32'd9; multiplier = 32'd11; enable = 1'b1;
        @(negedge clk);
        enable = 1'b0;
        lat = -1;
        for (int i = 0; i < 40 && lat < 0; i++) begin
            @(negedge clk);
            if (done) lat = i;
        end
        chk("b2b_first_done_seen", 64'(lat >= 0), 64'd1);
        chk("b2b_first_product", product, 64'd99);
        multiplicand = 32'h1234; multiplier = 32'h5678; enable = 1'b1;
        @(negedge clk);
        chk("b2b_second_busy", 64'(busy), 64'd1);
        enable = 1'b0;
        lat = -1;
        for (int i = 2; i < 45 && lat < 0; i++) begin
            multiplicand = $urandom; multiplier = $urandom;
            @(negedge clk);
            if (done) lat = i;
        end
        chk("b2b_second_lat", 64'(lat), 64'(W + 1));
        chk("b2b_second_product", product, 64'd103153760);

        // randomized operations, checked cycle by cycle against the model
        for (int r = 0; r < 25; r++) begin
            logic [W-1:0] ra, rb;
            ra = ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 255)) : W'($urandom);
            rb = ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 255)) : W'($urandom);
            op(ra, rb, int'($urandom_range(1, 45)), 1'($urandom_range(0, 1)), lat);
        end

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
